// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline register-file write path.
// Holds the arbiter state encoding, grant sources and the well-known save registers.
package pipeline_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;

    // Return-address save targets used by the exception unit.
    localparam logic [4:0] REG_K0 = 5'd26;
    localparam logic [4:0] REG_RA = 5'd31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_WB   = 2'd1,
        SRC_EXC  = 2'd2,
        SRC_PEND = 2'd3
    } grant_src_t;

endpackage

// File: rtl/rf_req_buffer.sv
// One-entry holding register for a deferred exception-unit write request.
// Load captures address/data and marks the entry valid; clear drops it.
module rf_req_buffer
    import pipeline_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    // Load wins over clear; the arbiter never asks for both in one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            addr  <= load_addr;
            data  <= load_data;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipeline_rf_write_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and
// the exception unit, bounding exception starvation with a one-cycle forced stall.
module pipeline_rf_write_arbiter
    import pipeline_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              exc_valid,
    input  logic [ADDR_W-1:0] exc_addr,
    input  logic [DATA_W-1:0] exc_data,
    output logic              exc_ready,
    output logic              pipe_stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    arb_state_t        state;
    arb_state_t        state_next;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  wait_cnt_next;
    grant_src_t        sel;
    logic              buf_load;
    logic              buf_clear;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;
    logic              win_valid;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    rf_req_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_pend_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (buf_load),
        .clear     (buf_clear),
        .load_addr (exc_addr),
        .load_data (exc_data),
        .valid     (pend_valid),
        .addr      (pend_addr),
        .data      (pend_data)
    );

    assign exc_ready  = (state == IDLE);
    assign pipe_stall = (state == FORCE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Writeback always wins a contested slot; a deferred exception request is
    // drained on the first idle writeback cycle or, after MAX_WAIT losses, by FORCE.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        sel           = SRC_NONE;
        buf_load      = 1'b0;
        buf_clear     = 1'b0;
        case (state)
            IDLE: begin
                if (wb_valid && exc_valid) begin
                    sel           = SRC_WB;
                    buf_load      = 1'b1;
                    state_next    = PEND;
                    wait_cnt_next = CNT_W'(1);
                end else if (wb_valid) begin
                    sel = SRC_WB;
                end else if (exc_valid) begin
                    sel = SRC_EXC;
                end
            end
            PEND: begin
                if (!wb_valid) begin
                    sel           = SRC_PEND;
                    buf_clear     = 1'b1;
                    state_next    = IDLE;
                    wait_cnt_next = '0;
                end else begin
                    sel = SRC_WB;
                    if (wait_cnt >= MAX_CNT) begin
                        state_next = FORCE;
                    end else begin
                        wait_cnt_next = wait_cnt + CNT_W'(1);
                    end
                end
            end
            FORCE: begin
                sel           = SRC_PEND;
                buf_clear     = 1'b1;
                state_next    = IDLE;
                wait_cnt_next = '0;
            end
            default: begin
                state_next    = IDLE;
                wait_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        win_valid = 1'b0;
        win_addr  = '0;
        win_data  = '0;
        case (sel)
            SRC_WB: begin
                win_valid = 1'b1;
                win_addr  = wb_addr;
                win_data  = wb_data;
            end
            SRC_EXC: begin
                win_valid = 1'b1;
                win_addr  = exc_addr;
                win_data  = exc_data;
            end
            SRC_PEND: begin
                win_valid = pend_valid;
                win_addr  = pend_addr;
                win_data  = pend_data;
            end
            default: begin
                win_valid = 1'b0;
            end
        endcase
    end

    // Register zero is hardwired, so a grant to it uses the slot but never writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= win_valid && (win_addr != '0);
            if (win_valid) begin
                rf_waddr <= win_addr;
                rf_wdata <= win_data;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_rf_write_arbiter.sv
// Self-checking bench for pipeline_rf_write_arbiter: directed scenarios plus
// randomized traffic scored against a transaction-level model of the arbiter.
module tb_pipeline_rf_write_arbiter;
    import pipeline_pkg::*;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int MAXW = 4;
    localparam int CW   = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          exc_valid;
    logic [AW-1:0] exc_addr;
    logic [DW-1:0] exc_data;
    logic          exc_ready;
    logic          pipe_stall;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: pending request, WB wins since it was deferred, forced-drain flag.
    bit            m_pend;
    logic [AW-1:0] m_pend_addr;
    logic [DW-1:0] m_pend_data;
    int            m_wins;
    bit            m_force;
    logic [DW-1:0] model_rf [32];
    logic [DW-1:0] dut_rf   [32];

    logic          exp_ready, exp_stall, exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          obs_ready, obs_stall, obs_we;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_data;

    always #5 clk = ~clk;

    pipeline_rf_write_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_WAIT (MAXW),
        .CNT_W    (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .exc_valid  (exc_valid),
        .exc_addr   (exc_addr),
        .exc_data   (exc_data),
        .exc_ready  (exc_ready),
        .pipe_stall (pipe_stall),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
    );

    // The register file captures the write port on the falling edge.
    always @(negedge clk) begin
        if (rf_we) dut_rf[rf_waddr] <= rf_wdata;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic model_reset();
        m_pend      = 1'b0;
        m_pend_addr = '0;
        m_pend_data = '0;
        m_wins      = 0;
        m_force     = 1'b0;
    endtask

    // Drives one request cycle, predicts its outcome and samples the DUT.
    task automatic run_cycle(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                             input logic ev, input logic [AW-1:0] ea, input logic [DW-1:0] ed);
        bit            granted;
        logic [AW-1:0] ga;
        logic [DW-1:0] gd;
        wb_valid  = wv;
        wb_addr   = wa;
        wb_data   = wd;
        exc_valid = ev;
        exc_addr  = ea;
        exc_data  = ed;
        exp_ready = !m_pend;
        exp_stall = m_force;
        granted   = 1'b0;
        ga        = '0;
        gd        = '0;
        if (m_force || (m_pend && !wv)) begin
            granted = 1'b1;
            ga      = m_pend_addr;
            gd      = m_pend_data;
            m_pend  = 1'b0;
            m_force = 1'b0;
            m_wins  = 0;
        end else if (wv) begin
            granted = 1'b1;
            ga      = wa;
            gd      = wd;
            if (m_pend) begin
                if (m_wins == MAXW) m_force = 1'b1;
                else m_wins++;
            end else if (ev) begin
                m_pend      = 1'b1;
                m_pend_addr = ea;
                m_pend_data = ed;
                m_wins      = 1;
            end
        end else if (ev) begin
            granted = 1'b1;
            ga      = ea;
            gd      = ed;
        end
        exp_we   = granted && (ga != '0);
        exp_addr = ga;
        exp_data = gd;
        if (exp_we) model_rf[ga] = gd;
        #1;
        obs_ready = exc_ready;
        obs_stall = pipe_stall;
        @(posedge clk);
        @(negedge clk);
        #1;
        obs_we   = rf_we;
        obs_addr = rf_waddr;
        obs_data = rf_wdata;
    endtask

    task automatic idle_cycle();
        run_cycle(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        wb_valid  = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        exc_valid = 1'b0;
        exc_addr  = '0;
        exc_data  = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== '0)
            $display("[TB] FAIL reset_outputs: got we=%0b addr=%0d data=%h, want all zero",
                     rf_we, rf_waddr, rf_wdata);
        else n_pass++;
        n_checks++;
        if (exc_ready !== 1'b1 || pipe_stall !== 1'b0)
            $display("[TB] FAIL reset_handshake: got ready=%0b stall=%0b, want ready=1 stall=0",
                     exc_ready, pipe_stall);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_exc_only();
        run_cycle(1'b0, '0, '0, 1'b1, REG_K0, 32'h0040_0104);
        n_checks++;
        if (obs_we !== 1'b1 || obs_addr !== REG_K0 || obs_data !== 32'h0040_0104)
            $display("[TB] FAIL exc_only_write: got we=%0b addr=%0d data=%h, want we=1 addr=26 data=00400104",
                     obs_we, obs_addr, obs_data);
        else n_pass++;
        idle_cycle();
        n_checks++;
        if (obs_ready !== 1'b1 || obs_we !== 1'b0)
            $display("[TB] FAIL exc_only_after: got ready=%0b we=%0b, want ready=1 we=0", obs_ready, obs_we);
        else n_pass++;
    endtask

    task automatic test_wb_and_exc();
        run_cycle(1'b1, 5'd8, 32'h0000_00A5, 1'b1, REG_RA, 32'h0000_0100);
        n_checks++;
        if (obs_ready !== 1'b1 || obs_we !== 1'b1 || obs_addr !== 5'd8 || obs_data !== 32'hA5)
            $display("[TB] FAIL both_first: got ready=%0b we=%0b addr=%0d data=%h, want ready=1 we=1 addr=8 data=a5",
                     obs_ready, obs_we, obs_addr, obs_data);
        else n_pass++;
        idle_cycle();
        n_checks++;
        if (obs_ready !== 1'b0 || obs_we !== 1'b1 || obs_addr !== REG_RA || obs_data !== 32'h100)
            $display("[TB] FAIL both_second: got ready=%0b we=%0b addr=%0d data=%h, want ready=0 we=1 addr=31 data=100",
                     obs_ready, obs_we, obs_addr, obs_data);
        else n_pass++;
        idle_cycle();
        n_checks++;
        if (obs_ready !== 1'b1 || obs_we !== 1'b0)
            $display("[TB] FAIL both_drained: got ready=%0b we=%0b, want ready=1 we=0", obs_ready, obs_we);
        else n_pass++;
    endtask

    task automatic test_collision();
        run_cycle(1'b1, REG_K0, 32'h1, 1'b1, REG_K0, 32'h2);
        n_checks++;
        if (obs_we !== 1'b1 || obs_addr !== REG_K0 || dut_rf[26] !== 32'h1)
            $display("[TB] FAIL collision_wb_first: got we=%0b addr=%0d r26=%h, want we=1 addr=26 r26=1",
                     obs_we, obs_addr, dut_rf[26]);
        else n_pass++;
        idle_cycle();
        n_checks++;
        if (obs_we !== 1'b1 || dut_rf[26] !== 32'h2)
            $display("[TB] FAIL collision_final: got we=%0b r26=%h, want we=1 r26=2", obs_we, dut_rf[26]);
        else n_pass++;
    endtask

    task automatic test_starvation();
        int            wb_writes;
        int            stall_at;
        int            stalls;
        logic          stall_we;
        logic [AW-1:0] stall_addr;
        logic [DW-1:0] stall_data;
        run_cycle(1'b1, 5'd1, 32'h1000, 1'b1, REG_RA, 32'h0000_0400);
        wb_writes  = 0;
        stall_at   = -1;
        stalls     = 0;
        stall_we   = 1'b0;
        stall_addr = '0;
        stall_data = '0;
        for (int k = 0; k < 10; k++) begin
            run_cycle(1'b1, AW'(k + 2), 32'h2000 + k, 1'b0, '0, '0);
            if (obs_stall === 1'b1) begin
                stalls++;
                if (stall_at < 0) begin
                    stall_at   = k;
                    stall_we   = obs_we;
                    stall_addr = obs_addr;
                    stall_data = obs_data;
                end
            end else if (stall_at < 0 && obs_we === 1'b1 && obs_addr === AW'(k + 2)) begin
                wb_writes++;
            end
        end
        n_checks++;
        if (wb_writes !== 4 || stall_at !== 4)
            $display("[TB] FAIL starve_wb_count: got wb_writes=%0d stall_at=%0d, want wb_writes=4 stall_at=4",
                     wb_writes, stall_at);
        else n_pass++;
        n_checks++;
        if (stalls !== 1)
            $display("[TB] FAIL starve_stall_len: got %0d stall cycles, want 1", stalls);
        else n_pass++;
        n_checks++;
        if (stall_we !== 1'b1 || stall_addr !== REG_RA || stall_data !== 32'h400)
            $display("[TB] FAIL starve_drain: got we=%0b addr=%0d data=%h, want we=1 addr=31 data=400",
                     stall_we, stall_addr, stall_data);
        else n_pass++;
        n_checks++;
        if (dut_rf[6] !== 32'h0)
            $display("[TB] FAIL starve_ignored_wb: got r6=%h, want 0 (stalled WB must not write)", dut_rf[6]);
        else n_pass++;
    endtask

    task automatic test_addr_zero();
        run_cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0, '0);
        n_checks++;
        if (obs_we !== 1'b0)
            $display("[TB] FAIL addr_zero_wb: got we=%0b, want 0", obs_we);
        else n_pass++;
        run_cycle(1'b0, '0, '0, 1'b1, 5'd0, 32'h1234_5678);
        n_checks++;
        if (obs_we !== 1'b0 || obs_ready !== 1'b1)
            $display("[TB] FAIL addr_zero_exc: got we=%0b ready=%0b, want we=0 ready=1", obs_we, obs_ready);
        else n_pass++;
    endtask

    task automatic test_reset_in_pend();
        int writes;
        run_cycle(1'b1, 5'd9, 32'h11, 1'b1, REG_K0, 32'h22);
        n_checks++;
        if (obs_we !== 1'b1 || exc_ready !== 1'b0)
            $display("[TB] FAIL pend_setup: got we=%0b ready=%0b, want we=1 ready=0", obs_we, exc_ready);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if (rf_we !== 1'b0 || exc_ready !== 1'b1 || pipe_stall !== 1'b0)
            $display("[TB] FAIL async_reset: got we=%0b ready=%0b stall=%0b, want we=0 ready=1 stall=0",
                     rf_we, exc_ready, pipe_stall);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        writes = 0;
        for (int k = 0; k < 4; k++) begin
            idle_cycle();
            if (obs_we !== 1'b0) writes++;
        end
        n_checks++;
        if (writes !== 0 || dut_rf[26] === 32'h22)
            $display("[TB] FAIL reset_drop_pending: got %0d writes r26=%h, want 0 writes and r26 not 22",
                     writes, dut_rf[26]);
        else n_pass++;
    endtask

    task automatic test_random();
        logic          wv, ev;
        logic [AW-1:0] wa, ea;
        int            pick, bad_regs;
        for (int r = 0; r < 32; r++) model_rf[r] = dut_rf[r];
        for (int n = 0; n < 400; n++) begin
            wv   = ($urandom_range(0, 99) < 65);
            wa   = AW'($urandom_range(0, 31));
            ev   = ($urandom_range(0, 99) < 35);
            pick = $urandom_range(0, 19);
            ea   = (pick == 0) ? 5'd0 : ((pick < 10) ? REG_K0 : REG_RA);
            run_cycle(wv, wa, DW'($urandom), ev, ea, DW'($urandom));
            n_checks++;
            if (obs_ready !== exp_ready || obs_stall !== exp_stall)
                $display("[TB] FAIL rand_handshake[%0d]: got ready=%0b stall=%0b, want ready=%0b stall=%0b",
                         n, obs_ready, obs_stall, exp_ready, exp_stall);
            else n_pass++;
            n_checks++;
            if (obs_we !== exp_we || (exp_we && (obs_addr !== exp_addr || obs_data !== exp_data)))
                $display("[TB] FAIL rand_write[%0d]: got we=%0b addr=%0d data=%h, want we=%0b addr=%0d data=%h",
                         n, obs_we, obs_addr, obs_data, exp_we, exp_addr, exp_data);
            else n_pass++;
        end
        bad_regs = 0;
        for (int r = 1; r < 32; r++) if (dut_rf[r] !== model_rf[r]) bad_regs++;
        n_checks++;
        if (bad_regs !== 0)
            $display("[TB] FAIL rand_regfile: got %0d differing registers, want 0", bad_regs);
        else n_pass++;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            dut_rf[r]   = '0;
            model_rf[r] = '0;
        end
        test_reset();
        test_exc_only();
        test_wb_and_exc();
        test_collision();
        test_starvation();
        test_addr_zero();
        test_reset_in_pend();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
